// File: rtl/twos_comp_rr_scheduler.sv
// Round-robin arbiter sharing one two's-complement negation unit among NUM_REQ
// requesters, with a one-entry tagged output register under valid/ready backpressure.
module twos_comp_rr_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 3,
    localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [ID_W-1:0]            out_id,
    output logic                       out_ovf
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  grant_idx;
    logic             found;
    logic             acc_en;
    logic             xfer;
    logic [WIDTH-1:0] op;

    // Modular add that stays correct when NUM_REQ is not a power of two.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                                 input int unsigned     off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_W'(s);
    endfunction

    // First valid requester at or after the pointer wins.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[wrap_add(ptr, k)]) begin
                found     = 1'b1;
                grant_idx = wrap_add(ptr, k);
            end
        end
    end

    assign out_valid = (state == FULL);
    assign acc_en    = !rst && (!out_valid || out_ready);
    assign xfer      = acc_en && found;
    assign req_ready = xfer ? (NUM_REQ'(1) << grant_idx) : '0;
    assign op        = req_data[grant_idx*WIDTH +: WIDTH];

    // Output register and priority pointer; pointer moves only on a transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            out_data <= '0;
            out_id   <= '0;
            out_ovf  <= 1'b0;
            ptr      <= '0;
        end else if (xfer) begin
            state    <= FULL;
            out_data <= WIDTH'(~op + WIDTH'(1));
            out_id   <= grant_idx;
            out_ovf  <= (op == MOST_NEG);
            ptr      <= wrap_add(grant_idx, 1);
        end else if (out_ready) begin
            state    <= EMPTY;
        end
    end

endmodule

// File: tb/tb_twos_comp_rr_scheduler.sv
// Directed bench for twos_comp_rr_scheduler: reset, single request, rotation,
// backpressure, operand boundaries and reset mid-operation.
module tb_twos_comp_rr_scheduler;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned WIDTH   = 3;
    localparam int unsigned ID_W    = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out_data;
    logic [ID_W-1:0]          out_id;
    logic                     out_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    twos_comp_rr_scheduler #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [2:0] d,
                             input logic [1:0] id, input logic ovf);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".data"},  32'(out_data),  32'(d));
        check({tag, ".id"},    32'(out_id),    32'(id));
        check({tag, ".ovf"},   32'(out_ovf),   32'(ovf));
    endtask

    task automatic set_ops(input logic [2:0] o0, input logic [2:0] o1,
                           input logic [2:0] o2, input logic [2:0] o3);
        req_data = {o3, o2, o1, o0};
    endtask

    // Inputs change at the falling edge; everything is sampled 1 time unit later.
    task automatic step;
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        set_ops(3'b001, 3'b010, 3'b011, 3'b111);

        // Reset held two cycles with all requesters valid
        for (int c = 0; c < 2; c++) begin
            step(); #1;
            check("rst.ready", 32'(req_ready), 32'h0);
            check_out("rst", 1'b0, 3'b000, 2'd0, 1'b0);
        end

        // Round-robin after release: 0,1,2,3,0
        step(); rst = 1'b0; #1;
        check("rr.ready0", 32'(req_ready), 32'b0001);
        step(); #1;
        check_out("rr0", 1'b1, 3'b111, 2'd0, 1'b0);
        check("rr.ready1", 32'(req_ready), 32'b0010);
        step(); #1;
        check_out("rr1", 1'b1, 3'b110, 2'd1, 1'b0);
        check("rr.ready2", 32'(req_ready), 32'b0100);
        step(); #1;
        check_out("rr2", 1'b1, 3'b101, 2'd2, 1'b0);
        check("rr.ready3", 32'(req_ready), 32'b1000);
        step(); #1;
        check_out("rr3", 1'b1, 3'b001, 2'd3, 1'b0);
        check("rr.wrap", 32'(req_ready), 32'b0001);
        step(); req_valid = 4'b0000; #1;
        check_out("rr4", 1'b1, 3'b111, 2'd0, 1'b0);
        step(); #1;
        check_out("drain", 1'b0, 3'b111, 2'd0, 1'b0);

        // Single request from requester 2 (pointer is 1)
        req_valid = 4'b0100; #1;
        check("single.ready", 32'(req_ready), 32'b0100);
        step(); req_valid = 4'b0000; #1;
        check_out("single", 1'b1, 3'b101, 2'd2, 1'b0);
        step(); #1;
        check_out("single.drop", 1'b0, 3'b101, 2'd2, 1'b0);

        // Backpressure: refill with 3'b101 from requester 2 (pointer is 3)
        req_valid = 4'b0100; #1;
        check("bp.fill", 32'(req_ready), 32'b0100);
        step(); out_ready = 1'b0; req_valid = 4'b1111; #1;
        for (int c = 0; c < 3; c++) begin
            check("bp.ready", 32'(req_ready), 32'h0);
            check_out("bp.hold", 1'b1, 3'b101, 2'd2, 1'b0);
            if (c < 2) begin step(); #1; end
        end
        step(); #1;
        check_out("bp.hold4", 1'b1, 3'b101, 2'd2, 1'b0);
        out_ready = 1'b1; #1;
        check("bp.release", 32'(req_ready), 32'b1000);
        step(); req_valid = 4'b0000; #1;
        check_out("bp.next", 1'b1, 3'b001, 2'd3, 1'b0);
        step(); #1;
        check_out("bp.drain", 1'b0, 3'b001, 2'd3, 1'b0);

        // Boundaries: 000 -> 000, 100 -> 100 ovf, 111 -> 001 (pointer is 0)
        set_ops(3'b000, 3'b100, 3'b111, 3'b000);
        req_valid = 4'b0111; #1;
        check("bnd.ready0", 32'(req_ready), 32'b0001);
        step(); #1;
        check_out("bnd.zero", 1'b1, 3'b000, 2'd0, 1'b0);
        check("bnd.ready1", 32'(req_ready), 32'b0010);
        step(); #1;
        check_out("bnd.mneg", 1'b1, 3'b100, 2'd1, 1'b1);
        check("bnd.ready2", 32'(req_ready), 32'b0100);
        step(); req_valid = 4'b0000; #1;
        check_out("bnd.m1", 1'b1, 3'b001, 2'd2, 1'b0);
        step(); #1;
        check_out("bnd.drain", 1'b0, 3'b001, 2'd2, 1'b0);

        // Reset mid-operation: fill from requester 1 (pointer -> 2), stall, reset
        set_ops(3'b001, 3'b011, 3'b001, 3'b001);
        req_valid = 4'b0010; out_ready = 1'b0; #1;
        check("mid.ready", 32'(req_ready), 32'b0010);
        step(); req_valid = 4'b0000; #1;
        check_out("mid.full", 1'b1, 3'b101, 2'd1, 1'b0);
        rst = 1'b1; req_valid = 4'b1111; #1;
        check("mid.rst_ready", 32'(req_ready), 32'h0);
        step(); rst = 1'b0; out_ready = 1'b1; #1;
        check_out("mid.cleared", 1'b0, 3'b000, 2'd0, 1'b0);
        check("mid.first", 32'(req_ready), 32'b0001);
        step(); req_valid = 4'b0000; #1;
        check_out("mid.after", 1'b1, 3'b111, 2'd0, 1'b0);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/twos_comp_rr_scheduler.md
Name: twos_comp_rr_scheduler

Overview:
- Shares a single WIDTH-bit two's-complement negation unit (result = ~x + 1, modulo 2^WIDTH) among NUM_REQ requesters.
- Each requester presents operands on a valid/ready channel.
- A round-robin scheduler grants one requester per cycle.
- The result is held in a one-entry output register, tagged with the source id, on a valid/ready output channel with backpressure.

Parameters:
- NUM_REQ, 4, number of requester channels (>= 2).
- WIDTH, 3, operand/result width in bits (>= 2).
- ID_W, $clog2(NUM_REQ), width of out_id (derived; not overridden).

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  bit i = requester i has an operand.
- req_data  input  NUM_REQ*WIDTH  operand i in bits [i*WIDTH +: WIDTH].
- req_ready  output  NUM_REQ  bit i = operand i accepted this cycle (one-hot or zero).
- out_valid  output  1  result register holds valid data.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  two's complement of accepted operand.
- out_id  output  ID_W  index of the requester that supplied the operand.
- out_ovf  output  1  operand was the most-negative value (1 followed by zeros); result equals the operand.

Behaviour:
- Interface: one clock; reset is synchronous and active-high; clock port clk, reset port rst.
- Reset values: out_valid=0, out_data=0, out_id=0, out_ovf=0, rr pointer=0 (requester 0 has highest priority first).
- Output register states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- Accept enable: acc_en = !rst & (EMPTY | out_ready). Draining and refilling in the same cycle is allowed, giving full throughput of 1 result/cycle.
- Grant:
  - Search req_valid starting at the pointer, wrapping at NUM_REQ-1 -> 0.
  - The first set bit wins.
  - req_ready = acc_en ? onehot(winner) : 0.
  - req_ready may depend combinationally on req_valid and out_ready.
  - req_valid must not depend on req_ready.
- Transfer on req_valid[i] & req_ready[i]. At the next edge:
  - out_data <= ~op + 1, truncated to WIDTH.
  - out_id <= i, out_ovf <= (op == 1<<(WIDTH-1)), out_valid <= 1.
  - pointer <= (i+1) mod NUM_REQ.
- Latency: 1 cycle from accepting edge to out_valid.
- If out_ready & out_valid and no request is granted: out_valid <= 0. out_data, out_id and out_ovf hold their last values.
- If FULL & !out_ready: out_data, out_id, out_ovf and out_valid are held stable, all req_ready=0, and the pointer is unchanged.
- Pointer changes only on a transfer. An idle cycle does not rotate priority.
- Operand 0 -> result 0, out_ovf=0.
- rst asserted mid-operation: the next edge returns all state to reset values. Any held result is discarded, not delivered. req_ready=0 while rst=1.
- Fairness: with all requesters continuously valid and out_ready=1, each requester is granted exactly once per NUM_REQ consecutive transfers.

Test Plan:
- Reset: hold rst 2 cycles with all req_valid=1 -> req_ready=0, out_valid=0, out_data=0, out_id=0 throughout. First grant after release goes to requester 0.
- Single request: req_valid=4'b0100, op2=3'b011, out_ready=1 -> req_ready=4'b0100 that cycle. Next cycle out_valid=1, out_data=3'b101, out_id=2, out_ovf=0. out_valid drops the following cycle.
- Round-robin: all valid, ops 0:3'b001, 1:3'b010, 2:3'b011, 3:3'b111, out_ready=1 -> out_id sequence 0,1,2,3,0, one per cycle. out_data sequence 3'b111, 3'b110, 3'b101, 3'b001, 3'b111.
- Backpressure: result 3'b101 held, out_ready=0 for 3 cycles with req_valid=4'b1111 -> req_ready=0 and output stable for 3 cycles. When out_ready=1, the result drains and the next requester is accepted in that same cycle, with no bubble.
- Boundaries: op 3'b000 -> 3'b000, ovf=0. op 3'b100 -> 3'b100, ovf=1. op 3'b111 -> 3'b001, ovf=0. Pointer wraps 3 -> 0 after a requester-3 grant.
- Reset mid-operation: out_valid=1, out_ready=0, pointer=2, then rst for 1 cycle -> next cycle out_valid=0, pending result never seen. After release with all valid, first grant goes to requester 0.
